// File: rtl/l2_arbiter_pkg.sv
// Shared definitions for the L2 arbiter and the cache controllers that talk to it.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package l2_arbiter_pkg;

   // Width of every burst_size field on the cache and L2 sides.
   localparam int BURST_W = 5;

   // Requester index constants. They also encode the owner / last-grant value.
   localparam logic [1:0] REQ_NONE = 2'd0;
   localparam logic [1:0] REQ_I    = 2'd1;
   localparam logic [1:0] REQ_D    = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      TAIL  = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = REQ_NONE,
      GNT_I    = REQ_I,
      GNT_D    = REQ_D
   } gnt_t;

   // A burst_size of zero still moves one beat.
   function automatic logic [BURST_W-1:0] beats_of(input logic [BURST_W-1:0] size);
      return (size == '0) ? BURST_W'(1) : size;
   endfunction

endpackage

// File: rtl/l2_req_slot.sv
// Per-requester pending slot: captures a one-cycle rreq/wreq pulse with its addr/size.
// Latency: the request is visible on vld in the pulse cycle itself (bypass), then held.
// Backpressure: pulses are dropped while the slot is already pending or the requester owns the bus.
// Ports: clk/reset; rreq/wreq/addr/burst_size from the cache; owns/grant from the arbiter;
//        vld/is_wr/vld_addr/vld_size describe the pending-or-arriving request.
module l2_req_slot
   import l2_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               rreq,
   input  logic               wreq,
   input  logic [31:0]        addr,
   input  logic [BURST_W-1:0] burst_size,
   input  logic               owns,
   input  logic               grant,
   output logic               vld,
   output logic               is_wr,
   output logic [31:0]        vld_addr,
   output logic [BURST_W-1:0] vld_size
);

   logic               pend_q;
   logic               wr_q;
   logic [31:0]        addr_q;
   logic [BURST_W-1:0] size_q;
   logic               cap;

   assign cap = (rreq | wreq) & ~pend_q & ~owns;

   // An arriving pulse is offered to the arbiter in the same cycle so an idle
   // arbiter can issue on the very next edge without a round trip through the slot.
   assign vld      = pend_q | cap;
   assign is_wr    = pend_q ? wr_q   : wreq;
   assign vld_addr = pend_q ? addr_q : addr;
   assign vld_size = pend_q ? size_q : burst_size;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= 1'b0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         size_q <= '0;
      end else if (grant) begin
         pend_q <= 1'b0;
      end else if (cap) begin
         pend_q <= 1'b1;
         wr_q   <= wreq;
         addr_q <= addr;
         size_q <= burst_size;
      end
   end

endmodule

// File: rtl/l2_arbiter.sv
// Two-requester (I-cache, D-cache) burst arbiter in front of a single L2 port.
// Latency: request pulse on an idle arbiter -> l2 pulse next cycle; zero added cycles per beat.
// Backpressure: l2_busy stalls the beat counter; k_busy is low only on owner beats with l2_busy=0.
// Ports: clk, reset (async active-low); per requester k in {i,d}: k_rreq, k_wreq, k_addr,
//        k_burst_size, k_wdata in, k_rdata, k_busy out; L2 side: l2_rreq, l2_wreq, l2_addr,
//        l2_burst_size, l2_wdata out, l2_rdata, l2_busy in.
module l2_arbiter
   import l2_arbiter_pkg::*;
#(
   parameter int D_PRIORITY = 1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_rreq,
   input  logic               i_wreq,
   input  logic [31:0]        i_addr,
   input  logic [BURST_W-1:0] i_burst_size,
   input  logic [31:0]        i_wdata,
   output logic [31:0]        i_rdata,
   output logic               i_busy,
   input  logic               d_rreq,
   input  logic               d_wreq,
   input  logic [31:0]        d_addr,
   input  logic [BURST_W-1:0] d_burst_size,
   input  logic [31:0]        d_wdata,
   output logic [31:0]        d_rdata,
   output logic               d_busy,
   output logic               l2_rreq,
   output logic               l2_wreq,
   output logic [31:0]        l2_addr,
   output logic [BURST_W-1:0] l2_burst_size,
   output logic [31:0]        l2_wdata,
   input  logic [31:0]        l2_rdata,
   input  logic               l2_busy
);

   arb_state_t         state_q, state_d;
   gnt_t               last_q, last_d, owner;
   logic [BURST_W-1:0] beat_q, beat_d;
   logic               l2_rreq_d, l2_wreq_d;
   logic [31:0]        l2_addr_d;
   logic [BURST_W-1:0] l2_size_d;

   logic               i_vld, i_wr, d_vld, d_wr;
   logic [31:0]        i_vaddr, d_vaddr;
   logic [BURST_W-1:0] i_vsize, d_vsize;
   logic               can_grant, pick_d, grant_i, grant_d;

   // The last grant doubles as the current owner whenever a burst is in flight.
   assign owner = (state_q == IDLE) ? GNT_NONE : last_q;

   l2_req_slot u_slot_i (
      .clk        (clk),
      .reset      (reset),
      .rreq       (i_rreq),
      .wreq       (i_wreq),
      .addr       (i_addr),
      .burst_size (i_burst_size),
      .owns       (owner == GNT_I),
      .grant      (grant_i),
      .vld        (i_vld),
      .is_wr      (i_wr),
      .vld_addr   (i_vaddr),
      .vld_size   (i_vsize)
   );

   l2_req_slot u_slot_d (
      .clk        (clk),
      .reset      (reset),
      .rreq       (d_rreq),
      .wreq       (d_wreq),
      .addr       (d_addr),
      .burst_size (d_burst_size),
      .owns       (owner == GNT_D),
      .grant      (grant_d),
      .vld        (d_vld),
      .is_wr      (d_wr),
      .vld_addr   (d_vaddr),
      .vld_size   (d_vsize)
   );

   // Grants happen from IDLE or straight out of TAIL. In TAIL the owner's own
   // slot is blocked, so only the other side can be chosen there.
   always_comb begin
      can_grant = (state_q == IDLE) || (state_q == TAIL);
      if (i_vld && d_vld) begin
         pick_d = (last_q == GNT_NONE) ? (D_PRIORITY != 0) : (last_q == GNT_I);
      end else begin
         pick_d = d_vld;
      end
      grant_i = can_grant & i_vld & ~pick_d;
      grant_d = can_grant & d_vld &  pick_d;
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      beat_d    = beat_q;
      l2_rreq_d = 1'b0;
      l2_wreq_d = 1'b0;
      l2_addr_d = l2_addr;
      l2_size_d = l2_burst_size;
      case (state_q)
         IDLE:  state_d = IDLE;
         ISSUE: state_d = XFER;
         XFER: begin
            if (!l2_busy) begin
               if ((beat_q + 1'b1) == beats_of(l2_burst_size)) begin
                  state_d = TAIL;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + 1'b1;
               end
            end
         end
         TAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (grant_i || grant_d) begin
         state_d   = ISSUE;
         last_d    = grant_d ? GNT_D : GNT_I;
         l2_rreq_d = grant_d ? ~d_wr : ~i_wr;
         l2_wreq_d = grant_d ?  d_wr :  i_wr;
         l2_addr_d = grant_d ? d_vaddr : i_vaddr;
         l2_size_d = grant_d ? d_vsize : i_vsize;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         last_q        <= GNT_NONE;
         beat_q        <= '0;
         l2_rreq       <= 1'b0;
         l2_wreq       <= 1'b0;
         l2_addr       <= '0;
         l2_burst_size <= '0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         beat_q        <= beat_d;
         l2_rreq       <= l2_rreq_d;
         l2_wreq       <= l2_wreq_d;
         l2_addr       <= l2_addr_d;
         l2_burst_size <= l2_size_d;
      end
   end

   assign i_busy   = ~((owner == GNT_I) && (state_q == XFER) && !l2_busy);
   assign d_busy   = ~((owner == GNT_D) && (state_q == XFER) && !l2_busy);
   assign l2_wdata = (owner == GNT_I) ? i_wdata :
                     (owner == GNT_D) ? d_wdata : '0;
   assign i_rdata  = l2_rdata;
   assign d_rdata  = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus a long randomized run,
// every cycle compared against a transaction-level model (owner, beats left, pending slots).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_l2_arbiter;
   import l2_arbiter_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               i_rreq, i_wreq, d_rreq, d_wreq;
   logic [31:0]        i_addr, d_addr, i_wdata, d_wdata, i_rdata, d_rdata;
   logic [BURST_W-1:0] i_burst_size, d_burst_size, l2_burst_size;
   logic               i_busy, d_busy;
   logic               l2_rreq, l2_wreq, l2_busy;
   logic [31:0]        l2_addr, l2_wdata, l2_rdata;

   l2_arbiter #(.D_PRIORITY(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_rreq        (i_rreq),
      .i_wreq        (i_wreq),
      .i_addr        (i_addr),
      .i_burst_size  (i_burst_size),
      .i_wdata       (i_wdata),
      .i_rdata       (i_rdata),
      .i_busy        (i_busy),
      .d_rreq        (d_rreq),
      .d_wreq        (d_wreq),
      .d_addr        (d_addr),
      .d_burst_size  (d_burst_size),
      .d_wdata       (d_wdata),
      .d_rdata       (d_rdata),
      .d_busy        (d_busy),
      .l2_rreq       (l2_rreq),
      .l2_wreq       (l2_wreq),
      .l2_addr       (l2_addr),
      .l2_burst_size (l2_burst_size),
      .l2_wdata      (l2_wdata),
      .l2_rdata      (l2_rdata),
      .l2_busy       (l2_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Stimulus for the next cycle (index 0 = i, 1 = d).
   bit          s_r [2];
   bit          s_w [2];
   logic [31:0] s_addr [2];
   logic [4:0]  s_size [2];
   bit          s_busy;

   // Reference model: who owns the L2 port, which phase of the burst we are in,
   // how many beats remain, and what each requester has waiting.
   int          m_owner;   // -1 none, 0 i, 1 d
   int          m_last;    // -1 none since reset
   int          m_left;
   bit          m_issue, m_xfer, m_tail, m_wr;
   logic [31:0] m_addr;
   logic [4:0]  m_size;
   bit          m_pend [2];
   bit          m_pwr  [2];
   logic [31:0] m_paddr [2];
   logic [4:0]  m_psize [2];

   int          i_lo, d_lo;
   logic [31:0] iss_q [$];

   task automatic model_reset();
      m_owner = -1; m_last = -1; m_left = 0;
      m_issue = 0; m_xfer = 0; m_tail = 0; m_wr = 0;
      m_addr = '0; m_size = '0;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 0; m_pwr[k] = 0; m_paddr[k] = '0; m_psize[k] = '0;
      end
   endtask

   task automatic clear_stim();
      for (int k = 0; k < 2; k++) begin
         s_r[k] = 0; s_w[k] = 0;
      end
   endtask

   task automatic drive_idle();
      i_rreq = 0; i_wreq = 0; i_addr = '0; i_burst_size = '0; i_wdata = '0;
      d_rreq = 0; d_wreq = 0; d_addr = '0; d_burst_size = '0; d_wdata = '0;
      l2_busy = 0; l2_rdata = '0;
   endtask

   task automatic model_step();
      int k;
      for (int r = 0; r < 2; r++) begin
         if ((s_r[r] || s_w[r]) && !m_pend[r] && m_owner != r) begin
            m_pend[r] = 1; m_pwr[r] = s_w[r]; m_paddr[r] = s_addr[r]; m_psize[r] = s_size[r];
         end
      end
      if (m_issue) begin
         m_issue = 0; m_xfer = 1;
      end else if (m_xfer) begin
         if (!s_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_xfer = 0; m_tail = 1;
            end
         end
      end else if (m_tail) begin
         m_tail = 0; m_owner = -1;
      end
      if (m_owner == -1 && (m_pend[0] || m_pend[1])) begin
         if (m_pend[0] && m_pend[1]) k = (m_last == 0 || m_last == -1) ? 1 : 0;
         else                        k = m_pend[1] ? 1 : 0;
         m_owner = k; m_last = k; m_issue = 1;
         m_wr    = m_pwr[k];
         m_addr  = m_paddr[k];
         m_size  = m_psize[k];
         m_left  = (m_psize[k] == 0) ? 1 : int'(m_psize[k]);
         m_pend[k] = 0;
      end
   endtask

   task automatic check_outputs();
      bit beat;
      beat = m_xfer && !s_busy;
      check_eq("l2_rreq", l2_rreq, m_issue && !m_wr);
      check_eq("l2_wreq", l2_wreq, m_issue && m_wr);
      check_eq("l2_addr", l2_addr, m_addr);
      check_eq("l2_burst_size", l2_burst_size, m_size);
      check_eq("i_busy", i_busy, !(beat && m_owner == 0));
      check_eq("d_busy", d_busy, !(beat && m_owner == 1));
      check_eq("l2_wdata", l2_wdata,
               (m_owner == 0) ? i_wdata : ((m_owner == 1) ? d_wdata : 32'h0));
      check_eq("i_rdata", i_rdata, l2_rdata);
      check_eq("d_rdata", d_rdata, l2_rdata);
      if (!i_busy) i_lo++;
      if (!d_busy) d_lo++;
      if (l2_rreq || l2_wreq) iss_q.push_back(l2_addr);
   endtask

   task automatic one_cycle();
      @(negedge clk);
      i_rreq = s_r[0]; i_wreq = s_w[0]; i_addr = s_addr[0]; i_burst_size = s_size[0];
      d_rreq = s_r[1]; d_wreq = s_w[1]; d_addr = s_addr[1]; d_burst_size = s_size[1];
      l2_busy  = s_busy;
      i_wdata  = $urandom;
      d_wdata  = $urandom;
      l2_rdata = $urandom;
      #1;
      check_outputs();
      model_step();
      clear_stim();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear at once.
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 0;
      #1;
      check_eq("rst_l2_rreq", l2_rreq, 0);
      check_eq("rst_l2_wreq", l2_wreq, 0);
      check_eq("rst_l2_addr", l2_addr, 0);
      check_eq("rst_l2_burst_size", l2_burst_size, 0);
      check_eq("rst_i_busy", i_busy, 1);
      check_eq("rst_d_busy", d_busy, 1);
      check_eq("rst_l2_wdata", l2_wdata, 0);
      model_reset();
      clear_stim();
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      reset = 1;
   endtask

   task automatic run_quiet(input int n);
      s_busy = 0;
      for (int c = 0; c < n; c++) one_cycle();
   endtask

   initial begin
      reset = 0;
      drive_idle();
      clear_stim();
      s_busy = 0;
      for (int k = 0; k < 2; k++) begin
         s_addr[k] = '0; s_size[k] = '0;
      end
      model_reset();
      do_reset();

      // Single i read burst of 8 on an idle arbiter, random l2 stalls.
      i_lo = 0;
      s_r[0] = 1; s_addr[0] = 32'h0000_1000; s_size[0] = 5'd8;
      one_cycle();
      @(posedge clk);
      #1;
      check_eq("req024_rreq_t1", l2_rreq, 1);
      check_eq("req024_addr", l2_addr, 32'h0000_1000);
      check_eq("req024_size", l2_burst_size, 8);
      for (int c = 0; c < 60; c++) begin
         s_busy = ($urandom_range(0, 2) == 0);
         one_cycle();
      end
      check_eq("req024_i_beats", i_lo, 8);

      // Tie right after reset: d first, then i.
      do_reset();
      iss_q.delete();
      s_r[0] = 1; s_addr[0] = 32'h0000_1000; s_size[0] = 5'd2;
      s_w[1] = 1; s_addr[1] = 32'h0000_2000; s_size[1] = 5'd3;
      run_quiet(30);
      check_eq("req025_n_issues", iss_q.size(), 2);
      check_eq("req025_first_d", iss_q[0], 32'h0000_2000);
      check_eq("req025_second_i", iss_q[1], 32'h0000_1000);

      // Three more tie rounds: grants keep alternating.
      iss_q.delete();
      for (int r = 0; r < 3; r++) begin
         s_r[0] = 1; s_addr[0] = 32'h0000_1000; s_size[0] = 5'd1;
         s_r[1] = 1; s_addr[1] = 32'h0000_2000; s_size[1] = 5'd2;
         run_quiet(15);
      end
      check_eq("req026_n_issues", iss_q.size(), 6);
      for (int g = 0; g < 6; g++) begin
         check_eq($sformatf("req026_grant%0d", g), iss_q[g],
                  (g % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
      end

      // d burst of 8 with l2_busy toggling every cycle.
      i_lo = 0; d_lo = 0;
      s_r[1] = 1; s_addr[1] = 32'h0000_5000; s_size[1] = 5'd8;
      for (int c = 0; c < 40; c++) begin
         s_busy = c[0];
         one_cycle();
      end
      check_eq("req027_d_beats", d_lo, 8);
      check_eq("req027_i_beats", i_lo, 0);

      // burst_size 0 moves one beat.
      i_lo = 0;
      s_w[0] = 1; s_addr[0] = 32'h0000_6000; s_size[0] = 5'd0;
      run_quiet(8);
      check_eq("req028_i_beats", i_lo, 1);

      // Reset around beat 4 of 8 with i pending: nothing issues afterwards.
      s_r[1] = 1; s_addr[1] = 32'h0000_3000; s_size[1] = 5'd8;
      run_quiet(2);
      s_r[0] = 1; s_addr[0] = 32'h0000_4000; s_size[0] = 5'd2;
      one_cycle();
      for (int c = 0; c < 20 && m_left > 4; c++) one_cycle();
      do_reset();
      iss_q.delete();
      run_quiet(10);
      check_eq("req029_no_pulse", iss_q.size(), 0);

      // Randomized traffic, including pulses that break the requester contract.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 9) == 0) begin
               if ($urandom_range(0, 1) == 1) s_w[k] = 1;
               else                           s_r[k] = 1;
               s_addr[k] = $urandom;
               s_size[k] = 5'($urandom_range(0, 6));
            end
         end
         s_busy = ($urandom_range(0, 2) == 0);
         one_cycle();
      end
      run_quiet(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
